// File: rtl/insn_fetch_pkg.sv
// insn_fetch_pkg: shared widths, defaults and helpers for the fetch stage
package insn_fetch_pkg;
  localparam int DEF_LEN_INSN = 32;
  localparam int DEF_LEN_PC = 16;
  localparam int DEF_RESET_PC = 0;
  localparam int FETCH_DEPTH = 4;
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/insn_fetch_fifo.sv
// insn_fetch_fifo: synchronous FIFO with flush; push at full accepted only alongside a pop
module insn_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(do_pop);
      wr <= wr + AW'(do_push);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/insn_fetch.sv
// insn_fetch: PC owner, credit-limited imem requests, prefetch FIFO to decoder, redirect flush.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter int LEN_INSN = DEF_LEN_INSN,
  parameter int LEN_PC = DEF_LEN_PC,
  parameter logic [LEN_PC-1:0] RESET_PC = LEN_PC'(DEF_RESET_PC),
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [LEN_PC-1:0]   imem_addr,
  input  logic                imem_resp_valid,
  input  logic [LEN_INSN-1:0] imem_resp_data,
  input  logic                redirect_valid,
  input  logic [LEN_PC-1:0]   redirect_pc,
  output logic                insn_valid,
  input  logic                insn_ready,
  output logic [LEN_INSN-1:0] insn,
  output logic [LEN_PC-1:0]   insn_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [LEN_PC-1:0] pc, qhead;
  logic [CW-1:0] outstanding, drop, out_next, dcount, qcount;
  logic [CW:0] credit;
  logic [LEN_INSN+LEN_PC-1:0] dhead;
  logic req_fire, resp_keep, pop, dempty, dfull, qempty, qfull, unused_bits;
  // outstanding + buffered never exceeds DEPTH, so a response always has a slot
  assign credit = {1'b0, outstanding} + {1'b0, dcount};
  assign imem_req_valid = !rst && !redirect_valid && (credit < (CW+1)'(DEPTH));
  assign imem_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp_keep = imem_resp_valid && drop == '0;
  assign insn_valid = !dempty;
  assign pop = insn_valid && insn_ready;
  assign {insn, insn_pc} = dhead;
  assign out_next = outstanding + CW'(req_fire) - CW'(imem_resp_valid);
  assign unused_bits = ^{dfull, qfull, qcount};
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
    end else begin
      outstanding <= out_next;
      pc <= redirect_valid ? redirect_pc : pc + LEN_PC'(req_fire);
      drop <= redirect_valid ? out_next : drop - CW'(imem_resp_valid && drop != '0);
    end
  end
  always_ff @(posedge clk)
    if (!rst) assert (!(imem_resp_valid && (outstanding == '0 || (resp_keep && qempty))));
  insn_fetch_fifo #(.WIDTH(LEN_INSN + LEN_PC), .DEPTH(DEPTH)) u_data (
    .clk(clk), .rst(rst), .push(resp_keep), .pop(pop), .flush(redirect_valid),
    .din({imem_resp_data, qhead}), .dout(dhead), .count(dcount), .full(dfull), .empty(dempty)
  );
  insn_fetch_fifo #(.WIDTH(LEN_PC), .DEPTH(DEPTH)) u_pcq (
    .clk(clk), .rst(rst), .push(req_fire), .pop(resp_keep), .flush(redirect_valid),
    .din(pc), .dout(qhead), .count(qcount), .full(qfull), .empty(qempty)
  );
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= sat_inc32(perf_fetched, pop);
      perf_stall <= sat_inc32(perf_stall, insn_ready && !insn_valid);
    end
  end
`endif
endmodule

// File: tb/tb_insn_fetch.sv
// tb_insn_fetch: scoreboard bench with a fixed-latency in-order imem model
module tb_insn_fetch;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_resp_valid = 0;
  logic [15:0] imem_addr, redirect_pc = 0, insn_pc;
  logic [31:0] imem_resp_data = 0, insn;
  logic redirect_valid = 0, insn_valid, insn_ready = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  insn_fetch dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  typedef struct { int due; logic [15:0] addr; } mreq_t;
  mreq_t mq[$];
  logic [47:0] sb[$];
  logic [15:0] seen[$];
  logic [15:0] model_pc, first_pc;
  logic [47:0] prev_head, e;
  bit rdy, irdy, redir, prev_hold, exp_empty_next, cap, obs_rv, obs_iv;
  logic [15:0] rpc;
  int cyc, lat = 1, nreq, npass, ntot, exp_f, exp_s, n0;
  function automatic logic [31:0] f(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic step();
    @(negedge clk);
    imem_req_ready = rdy;
    insn_ready = irdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_resp_valid = 0;
    if (rst) mq.delete();
    else if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_resp_valid = 1;
      imem_resp_data = f(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    obs_rv = imem_req_valid;
    obs_iv = insn_valid;
    if (rst) begin
      sb.delete();
      prev_hold = 0;
      exp_empty_next = 0;
      model_pc = 0;
      exp_f = 0;
      exp_s = 0;
    end else begin
      if (exp_empty_next) chk("redir_flush_valid", insn_valid, 0);
      exp_empty_next = 0;
      if (prev_hold && insn_valid) chk("hold_stable", {insn, insn_pc}, prev_head);
      prev_hold = insn_valid && !insn_ready;
      prev_head = {insn, insn_pc};
      if (insn_ready && !insn_valid) exp_s++;
      if (insn_valid && insn_ready) begin
        exp_f++;
        if (cap) begin first_pc = insn_pc; cap = 0; end
        if (sb.size() == 0) chk("unexpected_insn_valid", insn_valid, 0);
        else begin e = sb.pop_front(); chk("insn", {insn, insn_pc}, e); end
      end
      if (redir) begin
        chk("redir_noreq", imem_req_valid, 0);
        sb.delete();
        model_pc = rpc;
        exp_empty_next = 1;
        cap = 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("imem_addr", imem_addr, model_pc);
        sb.push_back({f(model_pc), model_pc});
        mq.push_back('{cyc + lat, imem_addr});
        seen.push_back(imem_addr);
        model_pc++;
        nreq++;
      end
    end
    cyc++;
  endtask
  task automatic drain();
    rdy = 0; irdy = 1; redir = 0;
    for (int i = 0; i < 40 && (mq.size() > 0 || sb.size() > 0 || insn_valid); i++) step();
    chk("drained", sb.size(), 0);
  endtask
  task automatic redirect_to(input logic [15:0] a);
    redir = 1; rpc = a;
    step();
    redir = 0;
  endtask
  initial begin
    rdy = 0; irdy = 0; redir = 0; rpc = 0;
    rst = 1;
    step(); step();
    chk("rst_req_valid", obs_rv, 0);
    chk("rst_insn_valid", obs_iv, 0);
    chk("rst_imem_addr", imem_addr, 0);
    // 1: back-to-back fetch from reset, latency 1
    rst = 0; rdy = 1; irdy = 1; lat = 1;
    step(); chk("t1_lat_c0", obs_iv, 0);
    step(); chk("t1_lat_c1", obs_iv, 0);
    step(); chk("t1_lat_c2", obs_iv, 1);
    step();
    chk("t1_reqs", nreq, 4);
    if (seen.size() >= 4) chk("t1_addr3", seen[3], 3);
    repeat (6) step();
    drain();
    // 2: credit limit with decoder stalled
    rdy = 1; irdy = 0; lat = 1; n0 = nreq;
    repeat (8) step();
    chk("t2_credit_reqs", nreq - n0, 4);
    chk("t2_credit_block", obs_rv, 0);
    irdy = 1; step();
    irdy = 0; step();
    chk("t2_credit_resume", obs_rv, 1);
    drain();
    // 3: redirect with three in flight, none returned yet
    rdy = 1; irdy = 1; lat = 4;
    repeat (3) step();
    redirect_to(16'h0040);
    rdy = 1;
    repeat (8) step();
    drain();
    chk("t3_first_pc", first_pc, 16'h0040);
    // 4: redirect coinciding with a response and a pending request
    rdy = 1; irdy = 1; lat = 3;
    repeat (3) step();
    rdy = 1;
    redirect_to(16'h0080);
    repeat (8) step();
    drain();
    chk("t4_first_pc", first_pc, 16'h0080);
    // 5: pc wrap
    rdy = 1; irdy = 1; lat = 1;
    redirect_to(16'hFFFE);
    seen.delete();
    rdy = 1;
    repeat (3) step();
    chk("t5_nreq", seen.size(), 3);
    if (seen.size() >= 3) chk("t5_wrap_addr", seen[2], 16'h0000);
    drain();
`ifdef FETCH_PERF_EN
    @(negedge clk); #1;
    chk("perf_fetched", perf_fetched, exp_f);
    chk("perf_stall", perf_stall, exp_s);
    rst = 1; step(); rst = 0;
    @(negedge clk); #1;
    chk("perf_fetched_rst", perf_fetched, 0);
    chk("perf_stall_rst", perf_stall, 0);
`endif
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
